// File: rtl/ping_sweep_scheduler.sv
// Sonar ping sequencer: BURST -> GUARD -> LISTEN -> REPORT, stepping the beam angle once per ping.
// Fixed ping period; the first echo strobe in LISTEN is captured and reported with the ping's angle.
module ping_sweep_scheduler #(
    parameter int BURST_CYCLES  = 524288,
    parameter int GUARD_CYCLES  = 1000,
    parameter int LISTEN_CYCLES = 16252928,
    parameter int ANGLE_WIDTH   = 7,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   enable_in,
    input  logic                   tof_valid_in,
    input  logic [15:0]            range_in,
    output logic                   burst_active_out,
    output logic                   ping_start_out,
    output logic                   listen_active_out,
    output logic [ANGLE_WIDTH-1:0] beam_angle_out,
    output logic                   result_valid_out,
    output logic                   result_hit_out,
    output logic [ANGLE_WIDTH-1:0] result_angle_out,
    output logic [15:0]            result_range_out,
    output logic                   sweep_done_out
);

    localparam int MAX_BG = (BURST_CYCLES > GUARD_CYCLES) ? BURST_CYCLES : GUARD_CYCLES;
    localparam int MAX_C  = (MAX_BG > LISTEN_CYCLES) ? MAX_BG : LISTEN_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    // The counter is loaded with (length - 1) on state entry and the state ends when it reaches zero.
    localparam logic [CW-1:0] BURST_LOAD  = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LOAD  = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LISTEN_LOAD = CW'(LISTEN_CYCLES - 1);

    localparam logic signed [ANGLE_WIDTH:0]   MAX_X  = (ANGLE_WIDTH+1)'(ANGLE_MAX);
    localparam logic signed [ANGLE_WIDTH:0]   STEP_X = (ANGLE_WIDTH+1)'(ANGLE_STEP);
    localparam logic        [ANGLE_WIDTH-1:0] MIN_A  = ANGLE_WIDTH'(ANGLE_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BURST,
        S_GUARD,
        S_LISTEN,
        S_REPORT
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            cnt_nxt;
    logic                     hit;
    logic [15:0]              cap_range;
    logic                     tof_here;
    logic                     hit_now;
    logic [15:0]              range_now;
    logic                     listen_last;
    logic signed [ANGLE_WIDTH:0] angle_sum;
    logic                     angle_wrap;
    logic [ANGLE_WIDTH-1:0]   angle_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        cnt_nxt           = cnt;
        burst_active_out  = 1'b0;
        ping_start_out    = 1'b0;
        listen_active_out = 1'b0;
        result_valid_out  = 1'b0;
        sweep_done_out    = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable_in) begin
                    state_nxt = S_BURST;
                    cnt_nxt   = BURST_LOAD;
                end
            end
            S_BURST: begin
                burst_active_out = 1'b1;
                ping_start_out   = (cnt == BURST_LOAD);
                if (cnt == '0) begin
                    if (GUARD_CYCLES > 0) begin
                        state_nxt = S_GUARD;
                        cnt_nxt   = GUARD_LOAD;
                    end else begin
                        state_nxt = S_LISTEN;
                        cnt_nxt   = LISTEN_LOAD;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_GUARD: begin
                if (cnt == '0) begin
                    state_nxt = S_LISTEN;
                    cnt_nxt   = LISTEN_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_LISTEN: begin
                listen_active_out = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_REPORT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_REPORT: begin
                result_valid_out = 1'b1;
                sweep_done_out   = angle_wrap;
                if (enable_in) begin
                    state_nxt = S_BURST;
                    cnt_nxt   = BURST_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Capture path folds in a strobe on the final LISTEN cycle so it lands in this ping's result.
    assign tof_here    = (state == S_LISTEN) && tof_valid_in;
    assign hit_now     = hit | tof_here;
    assign range_now   = hit ? cap_range : range_in;
    assign listen_last = (state == S_LISTEN) && (cnt == '0);

    assign angle_sum  = $signed({beam_angle_out[ANGLE_WIDTH-1], beam_angle_out}) + STEP_X;
    assign angle_wrap = (angle_sum > MAX_X);
    assign angle_nxt  = angle_wrap ? MIN_A : angle_sum[ANGLE_WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit              <= 1'b0;
            cap_range        <= '0;
            beam_angle_out   <= MIN_A;
            result_hit_out   <= 1'b0;
            result_range_out <= 16'hFFFF;
            result_angle_out <= MIN_A;
        end else begin
            if (tof_here && !hit) begin
                hit       <= 1'b1;
                cap_range <= range_in;
            end
            if (listen_last) begin
                result_hit_out   <= hit_now;
                result_range_out <= hit_now ? range_now : 16'hFFFF;
                result_angle_out <= beam_angle_out;
            end
            if (state == S_REPORT) begin
                hit            <= 1'b0;
                beam_angle_out <= angle_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ping_sweep_scheduler.sv
// Randomized scoreboard bench for ping_sweep_scheduler: one build with a guard window, one without.
// A ping-position reference model predicts control outputs and queues expected reports.
module tb_ping_sweep_scheduler;

    localparam int B     = 4;
    localparam int L     = 10;
    localparam int AW    = 7;
    localparam int AMIN  = -30;
    localparam int AMAX  = 30;
    localparam int ASTEP = 10;

    typedef struct {
        bit hit;
        int rng;
        int ang;
        bit done;
    } rep_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        tof;
    logic [15:0] rng;

    logic [1:0]          burst_o;
    logic [1:0]          ps_o;
    logic [1:0]          listen_o;
    logic [1:0]          rv_o;
    logic [1:0]          rh_o;
    logic [1:0]          sd_o;
    logic [1:0][AW-1:0]  ba_o;
    logic [1:0][AW-1:0]  ra_o;
    logic [1:0][15:0]    rr_o;

    ping_sweep_scheduler #(
        .BURST_CYCLES(B), .GUARD_CYCLES(2), .LISTEN_CYCLES(L), .ANGLE_WIDTH(AW),
        .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX), .ANGLE_STEP(ASTEP)
    ) u_dut (
        .clk_in(clk), .rst_in(rst), .enable_in(en), .tof_valid_in(tof), .range_in(rng),
        .burst_active_out(burst_o[0]), .ping_start_out(ps_o[0]), .listen_active_out(listen_o[0]),
        .beam_angle_out(ba_o[0]), .result_valid_out(rv_o[0]), .result_hit_out(rh_o[0]),
        .result_angle_out(ra_o[0]), .result_range_out(rr_o[0]), .sweep_done_out(sd_o[0])
    );

    ping_sweep_scheduler #(
        .BURST_CYCLES(B), .GUARD_CYCLES(0), .LISTEN_CYCLES(L), .ANGLE_WIDTH(AW),
        .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX), .ANGLE_STEP(ASTEP)
    ) u_dut_g0 (
        .clk_in(clk), .rst_in(rst), .enable_in(en), .tof_valid_in(tof), .range_in(rng),
        .burst_active_out(burst_o[1]), .ping_start_out(ps_o[1]), .listen_active_out(listen_o[1]),
        .beam_angle_out(ba_o[1]), .result_valid_out(rv_o[1]), .result_hit_out(rh_o[1]),
        .result_angle_out(ra_o[1]), .result_range_out(rr_o[1]), .sweep_done_out(sd_o[1])
    );

    // Model state: whether a ping is running and the cycle index within it.
    bit   m_run[2];
    int   m_pos[2];
    int   m_ang[2];
    bit   m_hit[2];
    int   m_rng[2];
    bit   e_rh[2];
    int   e_rr[2];
    int   e_ra[2];
    rep_t q0[$];
    rep_t q1[$];

    int vectors     = 0;
    int miscompares = 0;

    function automatic int g_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(string nm, int d, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_step(int d);
        int   p;
        int   cp;
        int   nxt;
        int   lst;
        rep_t r;
        p   = B + g_of(d) + L + 1;
        lst = B + g_of(d);
        cp  = m_pos[d];
        if (rst) begin
            m_run[d] = 0; m_pos[d] = 0; m_ang[d] = AMIN; m_hit[d] = 0; m_rng[d] = 0;
            e_rh[d] = 0; e_rr[d] = 'hFFFF; e_ra[d] = AMIN;
        end else if (!m_run[d]) begin
            if (en) begin
                m_run[d] = 1; m_pos[d] = 0; m_hit[d] = 0;
            end
        end else begin
            if (tof && !m_hit[d] && cp >= lst && cp < lst + L) begin
                m_hit[d] = 1;
                m_rng[d] = int'(rng);
            end
            if (cp == p - 1) begin
                nxt      = m_ang[d] + ASTEP;
                m_ang[d] = (nxt > AMAX) ? AMIN : nxt;
                m_hit[d] = 0;
                if (en) m_pos[d] = 0;
                else    m_run[d] = 0;
            end else begin
                m_pos[d] = cp + 1;
                if (m_pos[d] == p - 1) begin
                    r.hit  = m_hit[d];
                    r.rng  = m_hit[d] ? m_rng[d] : 'hFFFF;
                    r.ang  = m_ang[d];
                    r.done = (m_ang[d] + ASTEP > AMAX);
                    if (d == 0) q0.push_back(r);
                    else        q1.push_back(r);
                    e_rh[d] = r.hit; e_rr[d] = r.rng; e_ra[d] = r.ang;
                end
            end
        end
    endtask

    task automatic drive(bit r, bit e, bit t, logic [15:0] v);
        @(negedge clk);
        rst = r; en = e; tof = t; rng = v;
        model_step(0);
        model_step(1);
    endtask

    task automatic check_dut(int d);
        int   p;
        int   lst;
        bit   run;
        int   pos;
        bit   empty;
        rep_t r;
        p   = B + g_of(d) + L + 1;
        lst = B + g_of(d);
        run = m_run[d];
        pos = m_pos[d];
        chk("ping_start", d, int'(ps_o[d]), int'(run && pos == 0));
        chk("burst_active", d, int'(burst_o[d]), int'(run && pos < B));
        chk("listen_active", d, int'(listen_o[d]), int'(run && pos >= lst && pos < lst + L));
        chk("result_valid", d, int'(rv_o[d]), int'(run && pos == p - 1));
        chk("beam_angle", d, int'($signed(ba_o[d])), m_ang[d]);
        if (rv_o[d]) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_report dut%0d @%0t: got result_valid expected none", d, $time);
            end else begin
                r = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk("report_hit", d, int'(rh_o[d]), int'(r.hit));
                chk("report_range", d, int'(rr_o[d]), r.rng);
                chk("report_angle", d, int'($signed(ra_o[d])), r.ang);
                chk("sweep_done", d, int'(sd_o[d]), int'(r.done));
            end
        end else begin
            chk("sweep_done_quiet", d, int'(sd_o[d]), 0);
        end
        chk("held_hit", d, int'(rh_o[d]), int'(e_rh[d]));
        chk("held_range", d, int'(rr_o[d]), e_rr[d]);
        chk("held_angle", d, int'($signed(ra_o[d])), e_ra[d]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) check_dut(d);
        end
    end

    initial begin
        bit e_v;
        rst = 1'b1; en = 1'b0; tof = 1'b0; rng = '0;
        model_step(0);
        model_step(1);
        drive(1, 0, 0, 16'd0);
        drive(1, 0, 0, 16'd0);
        // Continuous sweep long enough to wrap the angle more than once.
        for (int i = 0; i < 320; i++)
            drive(0, 1, ($urandom_range(0, 5) == 0), 16'($urandom));
        // Enable toggled at random points, including mid-ping.
        e_v = 1'b1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 29) == 0) e_v = ~e_v;
            drive(0, e_v, ($urandom_range(0, 7) == 0), 16'($urandom));
        end
        // Occasional synchronous resets landing anywhere in the ping.
        e_v = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) e_v = ~e_v;
            drive(($urandom_range(0, 119) == 0), e_v, ($urandom_range(0, 11) == 0), 16'($urandom));
        end
        // Reset with enable and strobe held high: reset must win.
        drive(1, 1, 1, 16'd77);
        for (int i = 0; i < 40; i++)
            drive(0, 0, ($urandom_range(0, 3) == 0), 16'($urandom));
        @(posedge clk);
        #2;
        chk("reports_drained", 0, q0.size(), 0);
        chk("reports_drained", 1, q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
